// File: rtl/btn_pkg.sv
// btn_pkg: shared state codes, owner encoding and debounce default for btn_db_arb
package btn_pkg;
  localparam int DB_CNT_DEF = 500000;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT   = 3'd1;
  localparam logic [2:0] ST_COUNT   = 3'd2;
  localparam logic [2:0] ST_FIRE    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic OWN_C  = 1'b0;
  localparam logic OWN_SS = 1'b1;
endpackage

// File: rtl/db_timer.sv
// db_timer: shared saturating debounce counter
// Ports: clk, rst (async active-low), clr (zero the count), inc (advance the count),
//        hit (count has reached DB_CNT-1; the count holds there).
module db_timer
  import btn_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEF,
  parameter int CNT_W  = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);
  logic [CNT_W-1:0] r_cnt;
  assign hit = r_cnt == CNT_W'(DB_CNT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (inc && !hit) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/btn_db_arb.sv
// btn_db_arb: two-button debouncer sharing one counter, arbitrated per press
// Ports: clk, rst (async active-low), c_raw / ss_raw (raw async buttons),
//        c_btn / ss_btn (one-cycle accepted-press pulses), db_done (one-cycle
//        release-debounced pulse), busy (arbiter not idle).
// Option: define BTN_DB_RR_EN for round-robin tie breaking; default is c over ss.
module btn_db_arb
  import btn_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEF,
  parameter int CNT_W  = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic c_raw,
  input  logic ss_raw,
  output logic c_btn,
  output logic ss_btn,
  output logic db_done,
  output logic busy
);
  logic [1:0] r_c_sync, r_ss_sync;
  logic [2:0] r_state, w_next;
  logic r_owner, r_done;
  logic w_c_s, w_ss_s, w_own_s, w_hit, w_clr, w_inc, w_win;
  assign w_c_s   = r_c_sync[1];
  assign w_ss_s  = r_ss_sync[1];
  assign w_own_s = r_owner == OWN_SS ? w_ss_s : w_c_s;
`ifdef BTN_DB_RR_EN
  logic r_last;
  // On a tie, the button that fired last loses.
  assign w_win = (w_c_s && w_ss_s) ? ~r_last : (w_c_s ? OWN_C : OWN_SS);
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_last <= OWN_SS;
    else if (r_state == ST_COUNT && w_next == ST_FIRE) r_last <= r_owner;
`else
  assign w_win = w_c_s ? OWN_C : OWN_SS;
`endif
  assign w_next = r_state == ST_IDLE    ? ((w_c_s || w_ss_s) ? ST_GRANT : ST_IDLE) :
                  r_state == ST_GRANT   ? ST_COUNT :
                  r_state == ST_COUNT   ? (!w_own_s ? ST_IDLE : (w_hit ? ST_FIRE : ST_COUNT)) :
                  r_state == ST_FIRE    ? ST_RELEASE :
                  r_state == ST_RELEASE ? (w_hit ? ST_IDLE : ST_RELEASE) : ST_IDLE;
  // Press counts while held, release counts while low; a bounce during release restarts it.
  assign w_clr = r_state == ST_GRANT || r_state == ST_FIRE || (r_state == ST_RELEASE && w_own_s);
  assign w_inc = (r_state == ST_COUNT && w_own_s) || (r_state == ST_RELEASE && !w_own_s);
  db_timer #(.DB_CNT(DB_CNT), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst(rst), .clr(w_clr), .inc(w_inc), .hit(w_hit)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_c_sync  <= '0;
      r_ss_sync <= '0;
      r_state   <= ST_IDLE;
      r_owner   <= OWN_C;
      r_done    <= 1'b0;
    end else begin
      r_c_sync  <= {r_c_sync[0], c_raw};
      r_ss_sync <= {r_ss_sync[0], ss_raw};
      r_state   <= w_next;
      r_owner   <= (r_state == ST_IDLE && w_next == ST_GRANT) ? w_win : r_owner;
      r_done    <= r_state == ST_RELEASE && w_hit;
    end
  assign c_btn   = r_state == ST_FIRE && r_owner == OWN_C;
  assign ss_btn  = r_state == ST_FIRE && r_owner == OWN_SS;
  assign db_done = r_done;
  assign busy    = r_state != ST_IDLE;
endmodule

// File: tb/tb_btn_db_arb.sv
// tb_btn_db_arb: directed scoreboard bench for btn_db_arb with DB_CNT=4
module tb_btn_db_arb;
  localparam int DB = 4;
  localparam int K_C = 0;
  localparam int K_SS = 1;
  localparam int K_DN = 2;
`ifdef BTN_DB_RR_EN
  localparam int K_TIE2 = K_SS;
`else
  localparam int K_TIE2 = K_C;
`endif
  logic clk = 0, rst = 0, c_raw = 0, ss_raw = 0;
  logic c_btn, ss_btn, db_done, busy;
  int cyc = 0, checks = 0, failures = 0, c0 = 0;
  int exp_q[$];
  btn_db_arb #(.DB_CNT(DB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .c_raw(c_raw), .ss_raw(ss_raw),
    .c_btn(c_btn), .ss_btn(ss_btn), .db_done(db_done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] ev(input int k, input int c);
    return 32'(k * 65536 + c);
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    logic [31:0] o;
    if (c_btn || ss_btn || db_done) begin
      o = ev(c_btn ? K_C : (ss_btn ? K_SS : K_DN), cyc) | ((c_btn && ss_btn) ? 32'h0100_0000 : 32'h0);
      if (exp_q.size() == 0) check("unexpected_event", o, 32'hFFFF_FFFF);
      else check("event", o, ev(0, 0) | exp_q.pop_front());
    end
  end
  initial begin
    tick(2);
    check("rst_c_btn", {31'b0, c_btn}, 0);
    check("rst_ss_btn", {31'b0, ss_btn}, 0);
    check("rst_db_done", {31'b0, db_done}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    rst = 1;
    tick(3);
    c0 = cyc; c_raw = 1; ss_raw = 1;
    exp_q.push_back(ev(K_C, c0 + 8));
    tick(3);
    check("tie1_busy", {31'b0, busy}, 1);
    tick(7);
    c_raw = 0; ss_raw = 0;
    exp_q.push_back(ev(K_DN, cyc + 6));
    tick(10);
    check("tie1_idle", {31'b0, busy}, 0);
    c0 = cyc; c_raw = 1; ss_raw = 1;
    exp_q.push_back(ev(K_TIE2, c0 + 8));
    tick(10);
    c_raw = 0; ss_raw = 0;
    exp_q.push_back(ev(K_DN, cyc + 6));
    tick(10);
    c0 = cyc; c_raw = 1; ss_raw = 1;
    exp_q.push_back(ev(K_C, c0 + 8));
    tick(10);
    c_raw = 0;
    exp_q.push_back(ev(K_DN, c0 + 16));
    exp_q.push_back(ev(K_SS, c0 + 22));
    tick(16);
    ss_raw = 0;
    exp_q.push_back(ev(K_DN, c0 + 32));
    tick(10);
    c0 = cyc; ss_raw = 1;
    exp_q.push_back(ev(K_SS, c0 + 8));
    tick(20);
    ss_raw = 0;
    exp_q.push_back(ev(K_DN, c0 + 26));
    tick(10);
    c_raw = 1;
    tick(2);
    c_raw = 0;
    tick(1);
    check("glitch_busy", {31'b0, busy}, 1);
    tick(4);
    check("glitch_idle", {31'b0, busy}, 0);
    tick(4);
    c_raw = 1;
    tick(5);
    check("count_busy", {31'b0, busy}, 1);
    rst = 0;
    #1;
    check("arst_c_btn", {31'b0, c_btn}, 0);
    check("arst_ss_btn", {31'b0, ss_btn}, 0);
    check("arst_db_done", {31'b0, db_done}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    c_raw = 0;
    tick(2);
    rst = 1;
    tick(8);
    check("post_rst_idle", {31'b0, busy}, 0);
    c0 = cyc; c_raw = 1;
    exp_q.push_back(ev(K_C, c0 + 8));
    tick(8);
    c_raw = 0;
    exp_q.push_back(ev(K_DN, c0 + 14));
    tick(10);
    c0 = cyc; ss_raw = 1;
    exp_q.push_back(ev(K_SS, c0 + 8));
    tick(10);
    ss_raw = 0;
    tick(2);
    ss_raw = 1;
    tick(1);
    ss_raw = 0;
    exp_q.push_back(ev(K_DN, cyc + 6));
    tick(10);
    check("bounce_idle", {31'b0, busy}, 0);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_db_arb.md
BTN_DB_ARB -- requirements
Module: btn_db_arb

Interface
REQ-001 Parameter DB_CNT, default 500000, stable cycles needed to accept a press or a release (10 ms at 50 MHz); SHALL be at least 2.
REQ-002 Parameter CNT_W, default 19, debounce counter width; SHALL satisfy 2^CNT_W > DB_CNT.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 c_raw  in  1  raw clear pushbutton, asynchronous to clk.
REQ-006 ss_raw  in  1  raw start/stop pushbutton, asynchronous to clk.
REQ-007 c_btn  out  1  one-cycle pulse per accepted clear press.
REQ-008 ss_btn  out  1  one-cycle pulse per accepted start/stop press.
REQ-009 db_done  out  1  one-cycle pulse when a release completes debouncing (feeds the stopwatch controller's wait states).
REQ-010 busy  out  1  high whenever the state is not IDLE.

Function
REQ-011 Each raw input SHALL pass through its own 2-flop synchronizer; the arbiter SHALL use only the synchronized values (c_s, ss_s).
REQ-012 One debounce counter SHALL be shared by both buttons; at most one button SHALL own it at a time.
REQ-013 States: IDLE, GRANT, COUNT, FIRE, RELEASE.
REQ-014 IDLE: if c_s or ss_s is high, go to GRANT and latch the winner (owner); otherwise stay in IDLE.
REQ-015 Default arbitration when both are high in the same cycle: c_s wins.
REQ-016 GRANT: clear the counter, then go to COUNT.
REQ-017 COUNT: counter increments each cycle while owner_s stays high.
REQ-018 COUNT, owner_s low: return to IDLE with no pulse (glitch rejected).
REQ-019 COUNT, counter == DB_CNT-1 with owner_s high: go to FIRE.
REQ-020 FIRE: assert the owner's pulse output (c_btn or ss_btn) for exactly one cycle, clear the counter, then go to RELEASE.
REQ-021 RELEASE: counter increments while owner_s is low; any high cycle clears the counter.
REQ-022 RELEASE, counter == DB_CNT-1: assert db_done for one cycle and go to IDLE.
REQ-023 Requests from the non-owner SHALL be ignored outside IDLE and never queued; a button still held when IDLE returns is a new request.
REQ-024 Latency: for a clean press, the pulse SHALL be high in the cycle after edge DB_CNT+3, where edge 0 is the edge that first samples the raw input high.
REQ-025 All outputs SHALL be Moore-decoded from registered state; c_btn and ss_btn SHALL never be high in the same cycle.
REQ-026 Counter SHALL saturate and never wrap; it SHALL stay at or below DB_CNT-1.

Reset
REQ-027 While rst is low: state=IDLE; counter=0; synchronizers=0; owner=c; all outputs=0; round-robin pointer=ss.
REQ-028 Reset asserted mid-COUNT or mid-RELEASE SHALL abort without a pulse; after release, normal operation SHALL resume from IDLE.

Configuration
REQ-029 Macro BTN_DB_RR_EN, when defined, enables round-robin arbitration: on simultaneous requests in IDLE, the button not granted last wins.
REQ-030 With BTN_DB_RR_EN defined, the pointer updates only on entry to FIRE; after reset c wins the first tie.
REQ-031 Without BTN_DB_RR_EN, fixed priority applies (c over ss) and no pointer register exists.

Structure
REQ-032 Package btn_pkg SHALL hold the state enumeration, the owner encoding, and the DB_CNT default constant.
REQ-033 Sub-module db_timer SHALL implement the shared counter: inputs clr and inc; output hit when count == DB_CNT-1.

Verification (DB_CNT=4)
REQ-034 ss_raw high from edge 0 for 20 cycles -> ss_btn pulse after edge 7 only; after ss_raw falls, db_done pulses 5 cycles later.
REQ-035 c_raw high for 2 cycles, then low -> no c_btn pulse; busy returns low; state IDLE.
REQ-036 c_raw and ss_raw rise on the same edge, fixed mode -> c_btn pulse only; ss_btn pulses after c's db_done only if ss is still held.
REQ-037 Same as REQ-036 twice in a row with BTN_DB_RR_EN defined -> first tie grants c, second tie grants ss.
REQ-038 rst driven low at COUNT cycle 2 -> outputs 0 immediately; no pulse afterwards; a fresh press after reset is accepted with the REQ-024 latency.
REQ-039 ss_raw bouncing 1-0-1 during RELEASE -> counter restarts; db_done occurs 4 stable-low cycles after the last bounce.
